// File: rtl/rand_stream_gen.sv
// Rejection-sampling random stream generator: a Fibonacci LFSR feeds candidates, in-range ones are handed off over valid/ready.
// Optional macro RAND_ODD_ONLY_EN additionally restricts accepted values to odd numbers.
module rand_stream_gen #(
   parameter int          WIDTH     = 8,
   parameter int unsigned TAPS      = 32'h0000_00B8,
   parameter int unsigned SEED      = 1,
   parameter int unsigned LO        = 1,
   parameter int unsigned HI        = 10,
   parameter int unsigned COUNT_MAX = 5,
   localparam int         CW        = $clog2(COUNT_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             rnd_ready,
   output logic             rnd_valid,
   output logic [WIDTH-1:0] rnd_data,
   output logic [CW-1:0]    rnd_count,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] TAPS_W     = TAPS[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_W     = SEED[WIDTH-1:0];
   localparam logic [WIDTH-1:0] LO_W       = LO[WIDTH-1:0];
   localparam logic [WIDTH-1:0] HI_W       = HI[WIDTH-1:0];
   localparam logic [CW-1:0]    COUNT_LAST = CW'(COUNT_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GEN,
      S_HOLD,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [CW-1:0]    count_q, count_d;

   logic [WIDTH-1:0] lfsr_step;
   logic [CW-1:0]    count_inc;
   logic             in_range;
   logic             cand_ok;

   assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS_W)};
   assign count_inc = count_q + 1'b1;
   assign in_range  = (lfsr_q >= LO_W) && (lfsr_q <= HI_W);

`ifdef RAND_ODD_ONLY_EN
   assign cand_ok = in_range && lfsr_q[0];
`else
   assign cand_ok = in_range;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_W;
         data_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // A same-cycle seed load lands before GEN, so it becomes the first candidate.
            if (seed_load) begin
               lfsr_d = (seed_in == '0) ? SEED_W : seed_in;
            end
            if (start) begin
               state_d = S_GEN;
               count_d = '0;
            end
         end
         S_GEN: begin
            lfsr_d = lfsr_step;
            if (cand_ok) begin
               data_d  = lfsr_q;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (rnd_ready) begin
               valid_d = 1'b0;
               count_d = count_inc;
               state_d = (count_inc == COUNT_LAST) ? S_DONE : S_GEN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rnd_valid = valid_q;
   assign rnd_data  = data_q;
   assign rnd_count = count_q;
   assign busy      = (state_q == S_GEN) || (state_q == S_HOLD);
   assign done      = (state_q == S_DONE);

endmodule
